// File: rtl/mem_arbiter_if.sv
// Bundle of requester, memory and status signals for mem_arbiter.
// slave = arbiter side; master = environment side (both requesters and the memory).
interface mem_arbiter_if;
    logic         m0_req_i;
    logic         m0_write_i;
    logic [31:0]  m0_addr_i;
    logic [255:0] m0_data_i;
    logic         m0_ack_o;
    logic [255:0] m0_data_o;

    logic         m1_req_i;
    logic         m1_write_i;
    logic [31:0]  m1_addr_i;
    logic [255:0] m1_data_i;
    logic         m1_ack_o;
    logic [255:0] m1_data_o;

    logic         mem_enable_o;
    logic         mem_write_o;
    logic [31:0]  mem_addr_o;
    logic [255:0] mem_data_o;
    logic         mem_ack_i;
    logic [255:0] mem_data_i;

    logic         busy_o;
    logic         err_o;

    modport slave (
        input  m0_req_i, m0_write_i, m0_addr_i, m0_data_i,
        output m0_ack_o, m0_data_o,
        input  m1_req_i, m1_write_i, m1_addr_i, m1_data_i,
        output m1_ack_o, m1_data_o,
        output mem_enable_o, mem_write_o, mem_addr_o, mem_data_o,
        input  mem_ack_i, mem_data_i,
        output busy_o, err_o
    );

    modport master (
        output m0_req_i, m0_write_i, m0_addr_i, m0_data_i,
        input  m0_ack_o, m0_data_o,
        output m1_req_i, m1_write_i, m1_addr_i, m1_data_i,
        input  m1_ack_o, m1_data_o,
        input  mem_enable_o, mem_write_o, mem_addr_o, mem_data_o,
        output mem_ack_i, mem_data_i,
        input  busy_o, err_o
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port (dcache=m0, icache=m1) arbiter/sequencer for the shared 256-bit-line memory.
// Define ARB_ROUND_ROBIN_EN for round-robin tie breaking; otherwise m0 has fixed priority.
module mem_arbiter #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic         clk_i,
    input  logic         rst_i,
    mem_arbiter_if.slave bus
);
    localparam int unsigned TCW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } state_t;

    state_t         r_state;
    logic           r_grant;
    logic           r_write;
    logic [31:0]    r_addr;
    logic [255:0]   r_data;
    logic [TCW-1:0] r_tcnt;
    logic           r_err;
`ifdef ARB_ROUND_ROBIN_EN
    logic           r_last_grant;
`endif

    logic w_any_req;
    logic w_grant;
    logic w_busy;
    logic w_resp;

    assign w_any_req = bus.m0_req_i | bus.m1_req_i;

    always_comb begin
        w_grant = 1'b0;
        if (bus.m0_req_i && bus.m1_req_i) begin
`ifdef ARB_ROUND_ROBIN_EN
            w_grant = ~r_last_grant;
`else
            w_grant = 1'b0;
`endif
        end else if (bus.m1_req_i) begin
            w_grant = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state      <= IDLE;
            r_grant      <= 1'b0;
            r_write      <= 1'b0;
            r_addr       <= '0;
            r_data       <= '0;
            r_tcnt       <= '0;
            r_err        <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
            r_last_grant <= 1'b1;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any_req) begin
                        r_grant <= w_grant;
                        r_write <= w_grant ? bus.m1_write_i : bus.m0_write_i;
                        r_addr  <= w_grant ? bus.m1_addr_i  : bus.m0_addr_i;
                        r_data  <= w_grant ? bus.m1_data_i  : bus.m0_data_i;
                        r_tcnt  <= '0;
                        r_state <= BUSY;
`ifdef ARB_ROUND_ROBIN_EN
                        r_last_grant <= w_grant;
`endif
                    end
                end
                BUSY: begin
                    // Count saturates; err is raised on the cycle the count reaches TIMEOUT.
                    if (r_tcnt != TCW'(TIMEOUT)) begin
                        r_tcnt <= r_tcnt + TCW'(1);
                    end
                    if (r_tcnt >= TCW'(TIMEOUT - 1)) begin
                        r_err <= 1'b1;
                    end
                    if (bus.mem_ack_i) begin
                        r_state <= RESP;
                    end
                end
                RESP: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign w_busy = (r_state == BUSY);
    assign w_resp = (r_state == RESP);

    assign bus.mem_enable_o = w_busy;
    assign bus.mem_write_o  = w_busy & r_write;
    assign bus.mem_addr_o   = w_busy ? r_addr : '0;
    assign bus.mem_data_o   = w_busy ? r_data : '0;

    assign bus.m0_ack_o  = w_resp & ~r_grant;
    assign bus.m1_ack_o  = w_resp & r_grant;
    assign bus.m0_data_o = bus.m0_ack_o ? bus.mem_data_i : '0;
    assign bus.m1_data_o = bus.m1_ack_o ? bus.mem_data_i : '0;

    assign bus.busy_o = (r_state != IDLE);
    assign bus.err_o  = r_err;
endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: per-port expected-response queues, a 10-cycle memory stub
// and a line-level reference memory; grant order on ties is predicted from the arbitration rule.
module tb_mem_arbiter;
    localparam int unsigned TO = 64;

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    mem_arbiter_if bus ();

    mem_arbiter #(.TIMEOUT(TO)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus.slave)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    // Memory stub: acks on the 10th consecutive enable cycle, read line registered at the ack edge
    logic [255:0] mem_store [0:255];
    logic [3:0]   mcnt;
    logic [255:0] mdata;
    logic         mem_noack = 1'b0;

    assign bus.mem_ack_i  = bus.mem_enable_o && !mem_noack && (mcnt == 4'd9);
    assign bus.mem_data_i = mdata;

    always @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mcnt  <= '0;
            mdata <= '0;
        end else if (!bus.mem_enable_o) begin
            mcnt <= '0;
        end else if (bus.mem_ack_i) begin
            mcnt <= '0;
            if (bus.mem_write_o) begin
                mem_store[bus.mem_addr_o[12:5]] <= bus.mem_data_o;
                mdata <= bus.mem_data_o;
            end else begin
                mdata <= mem_store[bus.mem_addr_o[12:5]];
            end
        end else if (mcnt != 4'd15) begin
            mcnt <= mcnt + 4'd1;
        end
    end

    // Reference model state
    logic [255:0] ref_mem [0:255];
    logic [255:0] q0 [$];
    logic [255:0] q1 [$];
    int           ack_log [$];
    int           ack_cyc [$];
    int           ref_last = 1;

    function automatic void chk_v(input string nm, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, act, exp);
        end
    endfunction

    function automatic void chk_i(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d", nm, act, exp);
        end
    endfunction

    function automatic logic [255:0] rnd256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic do_txn(input int p, input logic wr, input logic [31:0] addr,
                          input logic [255:0] wdata, output int lat, output int en_cnt);
        logic [255:0] exp;
        logic [7:0]   idx;
        logic         got;
        idx = addr[12:5];
        if (wr) begin
            ref_mem[idx] = wdata;
            exp = wdata;
        end else begin
            exp = ref_mem[idx];
        end
        if (p == 0) q0.push_back(exp);
        else        q1.push_back(exp);
        @(negedge clk_i);
        if (p == 0) begin
            bus.m0_req_i = 1'b1; bus.m0_write_i = wr; bus.m0_addr_i = addr; bus.m0_data_i = wdata;
        end else begin
            bus.m1_req_i = 1'b1; bus.m1_write_i = wr; bus.m1_addr_i = addr; bus.m1_data_i = wdata;
        end
        lat = 0;
        en_cnt = 0;
        got = 1'b0;
        while (!got && lat < 400) begin
            @(negedge clk_i);
            lat++;
            if (bus.mem_enable_o) en_cnt++;
            got = (p == 0) ? bus.m0_ack_o : bus.m1_ack_o;
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL ack_wait_port%0d got no ack want ack within 400 cycles", p);
        end
        if (p == 0) bus.m0_req_i = 1'b0;
        else        bus.m1_req_i = 1'b0;
    endtask

    // Monitor: pops the expected line whenever a port acks, and checks idle data is zero
    initial begin
        forever begin
            @(negedge clk_i);
            if (rst_i) ref_last = 1;
            if (bus.m0_ack_o) begin
                if (q0.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_ack0 got ack want none");
                end else begin
                    chk_v("ack0_data", bus.m0_data_o, q0.pop_front());
                end
                ack_log.push_back(0); ack_cyc.push_back(cyc); ref_last = 0;
            end else begin
                chk_v("m0_data_idle_zero", bus.m0_data_o, '0);
            end
            if (bus.m1_ack_o) begin
                if (q1.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_ack1 got ack want none");
                end else begin
                    chk_v("ack1_data", bus.m1_data_o, q1.pop_front());
                end
                ack_log.push_back(1); ack_cyc.push_back(cyc); ref_last = 1;
            end else begin
                chk_v("m1_data_idle_zero", bus.m1_data_o, '0);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog got no finish want finish before 500000");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, en, s, first_last, r0, r1, w, last;
        int exp_seq [$];
        logic [255:0] d;

        bus.m0_req_i = 1'b0; bus.m0_write_i = 1'b0; bus.m0_addr_i = '0; bus.m0_data_i = '0;
        bus.m1_req_i = 1'b0; bus.m1_write_i = 1'b0; bus.m1_addr_i = '0; bus.m1_data_i = '0;

        // Reset state
        repeat (3) @(negedge clk_i);
        chk_i("rst_busy", int'(bus.busy_o), 0);
        chk_i("rst_err", int'(bus.err_o), 0);
        chk_i("rst_enable", int'(bus.mem_enable_o), 0);
        chk_i("rst_mem_write", int'(bus.mem_write_o), 0);
        chk_v("rst_mem_addr", {224'd0, bus.mem_addr_o}, '0);
        chk_v("rst_mem_data", bus.mem_data_o, '0);
        rst_i = 1'b0;

        // Single read of a preloaded line
        do_txn(0, 1'b1, 32'h0000_0040, {32{8'hA5}}, lat, en);
        do_txn(0, 1'b0, 32'h0000_0040, '0, lat, en);
        chk_i("rd_latency", lat, 11);
        chk_i("rd_enable_cycles", en, 10);

        // Write then read on port 1
        do_txn(1, 1'b1, 32'h0000_0100, 256'h1234, lat, en);
        chk_i("wr1_latency", lat, 11);
        do_txn(1, 1'b0, 32'h0000_0100, '0, lat, en);
        chk_i("rd1_latency", lat, 11);

        // Reset in the 5th BUSY cycle
        @(negedge clk_i);
        bus.m0_req_i = 1'b1; bus.m0_write_i = 1'b1; bus.m0_addr_i = 32'h0000_0300;
        bus.m0_data_i = rnd256();
        repeat (5) @(negedge clk_i);
        chk_i("midrst_busy_before", int'(bus.busy_o), 1);
        rst_i = 1'b1;
        #1;
        chk_i("midrst_busy", int'(bus.busy_o), 0);
        chk_i("midrst_enable", int'(bus.mem_enable_o), 0);
        chk_i("midrst_ack0", int'(bus.m0_ack_o), 0);
        chk_i("midrst_ack1", int'(bus.m1_ack_o), 0);
        chk_v("midrst_mem_addr", {224'd0, bus.mem_addr_o}, '0);
        chk_v("midrst_mem_data", bus.mem_data_o, '0);
        bus.m0_req_i = 1'b0;
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
        repeat (15) @(negedge clk_i);
        do_txn(0, 1'b1, 32'h0000_0300, rnd256(), lat, en);
        chk_i("post_rst_latency", lat, 11);
        do_txn(0, 1'b0, 32'h0000_0300, '0, lat, en);

        // Timeout with a memory that never acks
        mem_noack = 1'b1;
        @(negedge clk_i);
        bus.m0_req_i = 1'b1; bus.m0_write_i = 1'b0; bus.m0_addr_i = 32'h0000_0040;
        repeat (64) @(negedge clk_i);
        chk_i("err_before_timeout", int'(bus.err_o), 0);
        @(negedge clk_i);
        chk_i("err_at_timeout", int'(bus.err_o), 1);
        repeat (30) @(negedge clk_i);
        chk_i("err_sticky", int'(bus.err_o), 1);
        chk_i("busy_in_timeout", int'(bus.busy_o), 1);
        rst_i = 1'b1;
        #1;
        chk_i("err_cleared_by_rst", int'(bus.err_o), 0);
        chk_i("busy_cleared_by_rst", int'(bus.busy_o), 0);
        bus.m0_req_i = 1'b0;
        mem_noack = 1'b0;
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;

        // Continuous tie: predict grant order from the arbitration rule
        s = ack_log.size();
        first_last = ref_last;
        fork
            begin : tie0
                int l0, e0;
                for (int i = 0; i < 4; i++) do_txn(0, 1'b0, 32'h0000_0040, '0, l0, e0);
            end
            begin : tie1
                int l1, e1;
                for (int i = 0; i < 4; i++) do_txn(1, 1'b0, 32'h0000_0100, '0, l1, e1);
            end
        join
        r0 = 4; r1 = 4; last = first_last;
        while (r0 > 0 || r1 > 0) begin
            if (r0 > 0 && r1 > 0) begin
`ifdef ARB_ROUND_ROBIN_EN
                w = (last == 0) ? 1 : 0;
`else
                w = 0;
`endif
            end else begin
                w = (r0 > 0) ? 0 : 1;
            end
            exp_seq.push_back(w);
            if (w == 0) r0--; else r1--;
            last = w;
        end
        chk_i("tie_ack_count", ack_log.size() - s, 8);
        for (int k = 0; k < 8; k++) begin
            if (s + k < ack_log.size()) begin
                chk_i($sformatf("tie_grant_%0d", k), ack_log[s+k], exp_seq[k]);
                if (k > 0) chk_i($sformatf("tie_spacing_%0d", k), ack_cyc[s+k] - ack_cyc[s+k-1], 12);
            end
        end

        // Randomized concurrent traffic in disjoint line regions
        fork
            begin : rnd0
                int l0, e0;
                for (int i = 0; i < 4; i++) do_txn(0, 1'b1, 32'h0000_0200 + 32'(i * 32), rnd256(), l0, e0);
                for (int i = 0; i < 10; i++) begin
                    repeat ($urandom_range(0, 6)) @(negedge clk_i);
                    d = rnd256();
                    do_txn(0, 1'($urandom_range(0, 1)),
                           32'h0000_0200 + 32'($urandom_range(0, 3) * 32) + 32'($urandom_range(0, 31)),
                           d, l0, e0);
                end
            end
            begin : rnd1
                int l1, e1;
                for (int i = 0; i < 4; i++) do_txn(1, 1'b1, 32'h0000_0400 + 32'(i * 32), rnd256(), l1, e1);
                for (int i = 0; i < 10; i++) begin
                    repeat ($urandom_range(0, 6)) @(negedge clk_i);
                    do_txn(1, 1'($urandom_range(0, 1)),
                           32'h0000_0400 + 32'($urandom_range(0, 3) * 32) + 32'($urandom_range(0, 31)),
                           rnd256(), l1, e1);
                end
            end
        join

        repeat (5) @(negedge clk_i);
        chk_i("final_err", int'(bus.err_o), 0);
        chk_i("final_busy", int'(bus.busy_o), 0);
        chk_i("final_q0_empty", q0.size(), 0);
        chk_i("final_q1_empty", q1.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter and sequencer in front of the shared 256-bit-line data memory. Port 0 is the data cache and port 1 is the instruction cache. The block grants one requester at a time and latches its address, write flag and line data. It drives the memory enable for exactly one transaction, waits for the memory acknowledge, then returns the line and a one-cycle ack to the granted requester only.

## Interface
Parameters:
- TIMEOUT, 64: BUSY cycles without mem_ack_i before err_o sets (must be > 10).

Ports (N = 0, 1):
- clk_i  in  1  clock, rising edge
- rst_i  in  1  reset, asynchronous, active-high
- mN_req_i  in  1  request; held high until mN_ack_o is sampled
- mN_write_i  in  1  1 = line write, 0 = line read
- mN_addr_i  in  32  byte address; bits [4:0] are ignored by memory
- mN_data_i  in  256  write line
- mN_ack_o  out  1  one-cycle completion pulse
- mN_data_o  out  256  read line (for a write: the written line); valid while mN_ack_o = 1
- mem_enable_o  out  1  memory enable
- mem_write_o  out  1  memory write
- mem_addr_o  out  32  memory address
- mem_data_o  out  256  memory write line
- mem_ack_i  in  1  memory acknowledge
- mem_data_i  in  256  memory read line; registered by memory, valid the cycle after mem_ack_i
- busy_o  out  1  state != IDLE
- err_o  out  1  sticky timeout flag

## Operation
- States:
  - IDLE: sample requests. If any request is high, choose a grant, latch the requester's write/addr/data into internal registers, record grant_id, and go to BUSY.
  - BUSY: mem_enable_o = 1, and mem_write_o/addr/data come from the latched registers. On mem_ack_i = 1, go to RESP.
  - RESP: mem_enable_o = 0. Drive m{grant_id}_ack_o = 1 and m{grant_id}_data_o = mem_data_i. The other port's ack stays 0. Return to IDLE.
- mem_enable_o is combinational from the state (BUSY only). It drops on the same edge the memory leaves its wait state, so the memory never restarts spuriously.
- The latched values are stable for the whole of BUSY; requester inputs are ignored outside IDLE.
- mN_data_o is 0 whenever mN_ack_o = 0.
- Arbitration:
  - Only one requester: it is granted.
  - Both requesting: see Configuration.
- Timeout counter:
  - Cleared on entry to BUSY, increments each BUSY cycle, saturates at TIMEOUT.
  - Reaching TIMEOUT sets err_o. err_o clears only on reset.
  - The FSM stays in BUSY (no abort).
- Reset, including mid-transaction:
  - State IDLE; all outputs 0; latched registers 0; timeout count 0; err_o 0; last_grant = 1.
  - The memory shares rst_i, so no transaction survives reset.

## Timing
- Request sampled high in IDLE at cycle N: BUSY in cycles N+1..N+10, with the memory acking in N+10. RESP and mN_ack_o high in N+11. IDLE in N+12.
- A single transaction takes 12 cycles, request to next IDLE.
- Requesters must deassert req on the edge where they sample ack = 1. A req still high in IDLE (cycle N+12) starts a new transaction.
- Back-to-back from different ports: the second grant is sampled in N+12, giving 12-cycle spacing.
- A simultaneous new request and ack in RESP is legal. The new request is seen in the following IDLE.

## Configuration
- ARB_ROUND_ROBIN_EN defined:
  - On a tie, grant the port not equal to last_grant.
  - last_grant updates on every grant.
  - Reset value 1, so m0 wins the first tie.
- Undefined: fixed priority; m0 (data cache) always wins ties and last_grant is unused.

## Test plan
- Single read: preload line at 0x0000_0040 = 256'hA5…A5; m0 read 0x40 at cycle 0 -> mem_enable_o high cycles 1–10, m0_ack_o = 1 in cycle 11 with data A5…A5, m1_ack_o = 0 throughout.
- Write then read on port 1: write 0x0000_0100 = 256'h1234 then read it -> read ack returns 256'h1234; the write ack also carries 256'h1234.
- Tie, macro defined: m0 and m1 requesting together and continuously -> grants alternate m0, m1, m0, m1, with acks 12 cycles apart. Macro undefined -> m0 granted every time while held.
- Mid-transaction reset: pulse rst_i in cycle 5 of BUSY -> all outputs 0 immediately, busy_o = 0, no ack. A subsequent request completes normally in 11 cycles.
- Timeout: stub memory never acks, TIMEOUT = 64 -> err_o rises after 64 BUSY cycles and stays high; busy_o stays 1; reset clears both.
